ps2_frame_receiver: RTL and testbench

Upstream PS/2 front end of the keyboard controller.
- Receives 11-bit device-to-host PS/2 frames on the raw PS2_Clock/PS2_Data pins.
- Validates start, parity and stop bits.
- Presents the last two accepted scan-code bytes as a 16-bit buffer, plus a one-cycle strobe per new byte.
- Its KBBuffer output feeds the keyboard control logic, which decodes make/break sequences for the Port_ID-mapped read path.

---
 rtl/ps2_frame_receiver.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Device-to-host PS/2 frame receiver. Synchronises and deglitches the raw
//   PS/2 clock and data pins, shifts in 11-bit frames
//   (start, 8 data bits LSB first, odd parity, stop), and keeps the last two
//   accepted scan-code bytes in KBBuffer = {previous byte, newest byte}.
//   New_Code pulses for one cycle when KBBuffer changes. Frame_Error pulses
//   for one cycle when a frame is discarded.
//
//   Optional feature macro: PS2_PARITY_CHECK_EN
//     defined   - a frame with bad parity is dropped with a Frame_Error pulse.
//     undefined - the parity bit time is consumed, but its value is ignored.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,       // consecutive samples needed to change filtered clock (2..32)
  parameter int TIMEOUT_CYCLES = 100000   // max CLK cycles between falling edges inside a frame
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PS2_Clock,
  input  logic        PS2_Data,
  output logic [15:0] KBBuffer,
  output logic        New_Code,
  output logic        Frame_Error,
  output logic        Busy
);

  localparam int FILT_W = $clog2(FILTER_LEN);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              ps2_clk_s;
  logic              ps2_data_s;
  logic              filt_clk;
  logic [FILT_W-1:0] filt_cnt;
  logic              fe;

  assign ps2_clk_s  = clk_sync[1];
  assign ps2_data_s = data_sync[1];

  // Two-flop synchronisers for both pins. The idle line level is high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_Clock};
      data_sync <= {data_sync[0], PS2_Data};
    end
  end

  // Level filter: the filtered clock follows the pin only after FILTER_LEN
  // consecutive samples that disagree with it. fe is registered, so it is
  // high in the same cycle that filt_clk first reads 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (ps2_clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= ps2_clk_s;
        filt_cnt <= '0;
        fe       <= filt_clk;   // only a 1 -> 0 transition is a falling edge
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and datapath
  // ---------------------------------------------------------------------------
  state_t          state, state_next;
  logic [7:0]      shift_reg, shift_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [TO_W-1:0] to_cnt, to_cnt_next;
  logic [15:0]     kb_next;
  logic            new_code_next;
  logic            frame_err_next;
  logic            timeout_hit;
  logic            parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic            parity_bit, parity_next;

  // Odd parity over the 8 data bits plus the parity bit.
  assign parity_ok = ^{shift_reg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // The timeout applies only while a frame is open, and it wins over a coincident fe.
  assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST);

  // State register and the datapath registers that the next-state logic feeds.
  // The shift register is reset as well, so a byte aborted mid-frame leaves no residue.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      KBBuffer    <= '0;
      New_Code    <= 1'b0;
      Frame_Error <= 1'b0;
      Busy        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      bit_cnt     <= bit_cnt_next;
      to_cnt      <= to_cnt_next;
      KBBuffer    <= kb_next;
      New_Code    <= new_code_next;
      Frame_Error <= frame_err_next;
      Busy        <= (state_next != IDLE);
`ifdef PS2_PARITY_CHECK_EN
      parity_bit  <= parity_next;
`endif
    end
  end

  // Next-state and output logic. The FSM advances only on fe, except on timeout.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt;
    kb_next        = KBBuffer;
    new_code_next  = 1'b0;
    frame_err_next = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_next    = parity_bit;
`endif

    if (timeout_hit) begin
      state_next     = IDLE;
      frame_err_next = 1'b1;
    end else if (fe) begin
      unique case (state)
        IDLE: begin
          if (!ps2_data_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            shift_next   = '0;
          end else begin
            frame_err_next = 1'b1;   // a start bit must be 0
          end
        end
        DATA: begin
          shift_next = {ps2_data_s, shift_reg[7:1]};   // LSB arrives first
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_next = ps2_data_s;
`endif
          state_next  = STOP;
        end
        STOP: begin
          if (ps2_data_s && parity_ok) begin
            kb_next       = {KBBuffer[7:0], shift_reg};
            new_code_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // The timeout counter clears on every fe and in IDLE, and counts while a frame is open.
    if (state_next == IDLE || fe) begin
      to_cnt_next = '0;
    end else if (state != IDLE) begin
      to_cnt_next = to_cnt + TO_W'(1);
    end else begin
      to_cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver
//   Table-driven frame vectors plus hand-written sequences for bad start,
//   timeout, and mid-frame reset. The PS/2 clock runs scaled down
//   (HALF CLK cycles per phase), and TIMEOUT_CYCLES is reduced to match.
module tb_ps2_frame_receiver;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 40;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [15:0] kb;
  logic        nc;
  logic        ferr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int nc_cnt = 0, fe_cnt = 0, both_cnt = 0, long_cnt = 0;
  int last_nc_cyc = 0;
  int fall_cyc = 0;
  logic nc_q = 1'b0, fe_q = 1'b0;

  ps2_frame_receiver #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .PS2_Clock   (ps2_clk),
    .PS2_Data    (ps2_dat),
    .KBBuffer    (kb),
    .New_Code    (nc),
    .Frame_Error (ferr),
    .Busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (nc) begin
      nc_cnt++;
      last_nc_cyc = cyc;
    end
    if (ferr) fe_cnt++;
    if (nc && ferr) both_cnt++;
    if ((nc && nc_q) || (ferr && fe_q)) long_cnt++;
    nc_q = nc;
    fe_q = ferr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One PS/2 bit: data changes while the clock is high, then the clock falls and rises.
  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_dat = b;
    if (glitch) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 13) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                            input bit glitch, output int stop_fall);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit((~^d) ^ flip_par, glitch);
    send_bit(~bad_stop, glitch);
    stop_fall = fall_cyc;
    ps2_dat = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          flip_par;
    bit          bad_stop;
    bit          glitch;
    logic [15:0] exp_kb;
    int          exp_nc;
    int          exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nc0, fe0, sf;
    logic [7:0] partial;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 16'h001C, 1, 0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 16'h1CF0, 1, 0};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 16'hF01C, 1, 0};
    vecs[3] = '{8'h1C, 1'b1, 1'b0, 1'b0, (PAR_EN ? 16'hF01C : 16'h1C1C),
                (PAR_EN ? 0 : 1), (PAR_EN ? 1 : 0)};
    vecs[4] = '{8'h29, 1'b0, 1'b1, 1'b0, (PAR_EN ? 16'hF01C : 16'h1C1C), 0, 1};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1, 16'h1C5A, 1, 0};
    vecs[6] = '{8'hE0, 1'b0, 1'b0, 1'b0, 16'h5AE0, 1, 0};

    // Reset state
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_kb",   {16'h0, kb}, 32'h0);
    check("reset_nc",   {31'h0, nc}, 32'h0);
    check("reset_ferr", {31'h0, ferr}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      nc0 = nc_cnt; fe0 = fe_cnt;
      send_frame(vecs[v].data, vecs[v].flip_par, vecs[v].bad_stop, vecs[v].glitch, sf);
      check($sformatf("vec%0d_kb", v),   {16'h0, kb}, {16'h0, vecs[v].exp_kb});
      check($sformatf("vec%0d_nc", v),   nc_cnt - nc0, vecs[v].exp_nc);
      check($sformatf("vec%0d_fe", v),   fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("vec%0d_busy", v), {31'h0, busy}, 32'h0);
      if (vecs[v].exp_nc == 1)
        check($sformatf("vec%0d_latency_ok", v),
              {31'h0, (last_nc_cyc > sf) && (last_nc_cyc - sf <= FL + 4)}, 32'h1);
    end

    // Bad start bit: one falling edge with data high
    nc0 = nc_cnt; fe0 = fe_cnt;
    send_bit(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("badstart_fe",   fe_cnt - fe0, 1);
    check("badstart_nc",   nc_cnt - nc0, 0);
    check("badstart_busy", {31'h0, busy}, 32'h0);
    check("badstart_kb",   {16'h0, kb}, 32'h5AE0);

    // Timeout: start plus four data bits, then the clock is held high
    nc0 = nc_cnt; fe0 = fe_cnt;
    partial = 8'h29;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b0);
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    check("timeout_busy_mid", {31'h0, busy}, 32'h1);
    repeat (TO + 10) @(negedge clk);
    check("timeout_fe",   fe_cnt - fe0, 1);
    check("timeout_nc",   nc_cnt - nc0, 0);
    check("timeout_busy", {31'h0, busy}, 32'h0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, sf);
    check("after_timeout_kb_lo", {24'h0, kb[7:0]}, 32'h29);
    check("after_timeout_nc",    nc_cnt - nc0, 1);
    check("after_timeout_fe",    fe_cnt - fe0, 1);

    // Reset in the middle of a frame
    partial = 8'h76;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i], 1'b0);
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_busy_before", {31'h0, busy}, 32'h1);
    nc0 = nc_cnt; fe0 = fe_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_kb",   {16'h0, kb}, 32'h0);
    check("midreset_nc",   {31'h0, nc}, 32'h0);
    check("midreset_ferr", {31'h0, ferr}, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (TO + 50) @(negedge clk);
    check("midreset_no_pulse", (nc_cnt - nc0) + (fe_cnt - fe0), 0);
    send_frame(8'h76, 1'b0, 1'b0, 1'b0, sf);
    check("after_reset_kb", {16'h0, kb}, 32'h0076);
    check("after_reset_nc", nc_cnt - nc0, 1);
    check("after_reset_fe", fe_cnt - fe0, 0);

    // Pulse hygiene across the whole run
    check("pulses_never_coincide", both_cnt, 0);
    check("pulses_single_cycle",   long_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
